// File: rtl/mem_io_responder.sv
// rtl/mem_io_responder.sv - CPU memory-bus responder: 128KB byte RAM, UART TX FIFO, RX pop, cycle counter, stop flag
// Optional: define MEM_BOUNDS_CHECK_EN to flag and suppress out-of-range accesses (bad_access).
module mem_io_responder #(
    parameter int RAM_ADDR_WIDTH = 17,
    parameter int TX_FIFO_LOG2   = 3,
    parameter int FULL_MARGIN    = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] bus_addr,
    input  logic [7:0]  bus_wdata,
    input  logic        bus_wr,
    output logic [7:0]  bus_rdata,
    output logic        io_buffer_full,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_pop,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        program_stop,
    output logic        tx_overflow,
    output logic        bad_access
);

    localparam int DEPTH = 1 << TX_FIFO_LOG2;
    localparam logic [TX_FIFO_LOG2:0]   DEPTH_C    = (TX_FIFO_LOG2+1)'(DEPTH);
    localparam logic [TX_FIFO_LOG2:0]   FULL_LEVEL = (TX_FIFO_LOG2+1)'(DEPTH - FULL_MARGIN);
    localparam logic [TX_FIFO_LOG2:0]   CNT_ONE    = (TX_FIFO_LOG2+1)'(1);
    localparam logic [TX_FIFO_LOG2-1:0] PTR_ONE    = TX_FIFO_LOG2'(1);

    logic [7:0] ram  [0:(1<<RAM_ADDR_WIDTH)-1];
    logic [7:0] fifo [0:DEPTH-1];

    logic [TX_FIFO_LOG2-1:0] wr_ptr, rd_ptr;
    logic [TX_FIFO_LOG2:0]   count, count_next;
    logic [31:0]             counter, snapshot;

    logic                      oob, is_io, is_ram;
    logic                      sel_data, sel_cnt, sel_cnt0;
    logic [15:0]               io_off;
    logic [RAM_ADDR_WIDTH-1:0] ram_addr;
    logic                      push, push_ok, pop, full, overflow_set, stop_set;
    logic [7:0]                push_byte;

`ifdef MEM_BOUNDS_CHECK_EN
    assign oob = (bus_addr[31:18] != 14'd0) || (bus_addr[17:16] == 2'b10);
`else
    // Upper address bits are deliberately ignored: accesses alias into the RAM.
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus_addr[31:18];
    assign oob = 1'b0;
`endif

    assign is_io    = !oob && (bus_addr[17:16] == 2'b11);
    assign is_ram   = !oob && !is_io;
    assign io_off   = bus_addr[15:0];
    assign ram_addr = bus_addr[RAM_ADDR_WIDTH-1:0];
    assign sel_data = is_io && (io_off == 16'h0000);
    assign sel_cnt  = is_io && (io_off[15:2] == 14'h0001);
    assign sel_cnt0 = sel_cnt && (io_off[1:0] == 2'b00);

    assign rx_pop = rx_valid && sel_data && !bus_wr;

    // Once stopped, every IO write is ignored; the stop write itself pushes a 0x00 terminator.
    assign stop_set     = bus_wr && !program_stop && sel_cnt0;
    assign push         = bus_wr && !program_stop &&
                          ((sel_data && (bus_wdata != 8'h00)) || sel_cnt0);
    assign push_byte    = sel_data ? bus_wdata : 8'h00;
    assign tx_valid     = (count != '0);
    assign tx_data      = fifo[rd_ptr];
    assign pop          = tx_valid && tx_ready;
    assign full         = (count == DEPTH_C);
    assign push_ok      = push && (!full || pop);
    assign overflow_set = push && full && !pop;

    // Next FIFO occupancy, shared by the count register and the near-full flag.
    always_comb begin
        count_next = count;
        if (push_ok && !pop)
            count_next = count + CNT_ONE;
        else if (!push_ok && pop)
            count_next = count - CNT_ONE;
    end

    // RAM write port; contents survive reset.
    always_ff @(posedge clk_in) begin
        if (bus_wr && is_ram)
            ram[ram_addr] <= bus_wdata;
    end

    // FIFO storage; only the pointers are reset.
    always_ff @(posedge clk_in) begin
        if (push_ok)
            fifo[wr_ptr] <= push_byte;
    end

    // Registered read data; writes leave the previous value in place.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            bus_rdata <= 8'h00;
        end else if (!bus_wr) begin
            if (is_ram)
                bus_rdata <= ram[ram_addr];
            else if (sel_data)
                bus_rdata <= rx_valid ? rx_data : 8'h00;
            else if (sel_cnt) begin
                case (io_off[1:0])
                    2'd0:    bus_rdata <= counter[7:0];
                    2'd1:    bus_rdata <= snapshot[15:8];
                    2'd2:    bus_rdata <= snapshot[23:16];
                    default: bus_rdata <= snapshot[31:24];
                endcase
            end else
                bus_rdata <= 8'h00;
        end
    end

    // Control state: FIFO pointers, flags, cycle counter and its coherent snapshot.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            io_buffer_full <= 1'b0;
            program_stop   <= 1'b0;
            tx_overflow    <= 1'b0;
            counter        <= 32'd0;
            snapshot       <= 32'd0;
            bad_access     <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            count          <= count_next;
            io_buffer_full <= (count_next >= FULL_LEVEL);
            if (stop_set)
                program_stop <= 1'b1;
            if (overflow_set)
                tx_overflow <= 1'b1;
            counter <= counter + 32'd1;
            if (!bus_wr && sel_cnt0)
                snapshot <= counter;
            bad_access <= oob;
        end
    end

endmodule

// File: tb/tb_mem_io_responder.sv
// tb/tb_mem_io_responder.sv - directed self-checking bench for mem_io_responder
module tb_mem_io_responder;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [31:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic        bus_wr;
    logic [7:0]  bus_rdata;
    logic        io_buffer_full;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_pop;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        program_stop;
    logic        tx_overflow;
    logic        bad_access;

    int n_checks = 0;
    int n_fail   = 0;

    mem_io_responder dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .bus_addr       (bus_addr),
        .bus_wdata      (bus_wdata),
        .bus_wr         (bus_wr),
        .bus_rdata      (bus_rdata),
        .io_buffer_full (io_buffer_full),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_pop         (rx_pop),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .program_stop   (program_stop),
        .tx_overflow    (tx_overflow),
        .bad_access     (bad_access)
    );

    always #5 clk_in = ~clk_in;

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [7:0] d);
        bus_addr  = a;
        bus_wdata = d;
        bus_wr    = 1'b1;
        step();
    endtask

    task automatic bus_read(input logic [31:0] a);
        bus_addr = a;
        bus_wr   = 1'b0;
        step();
    endtask

    logic [7:0] exp_q1 [0:7];

    initial begin
        rst_in    = 1'b1;
        bus_addr  = 32'h0;
        bus_wdata = 8'h00;
        bus_wr    = 1'b0;
        rx_data   = 8'h00;
        rx_valid  = 1'b0;
        tx_ready  = 1'b0;
        step();
        step();
        check("rst_rdata", bus_rdata, 0);
        check("rst_iofull", io_buffer_full, 0);
        check("rst_txvalid", tx_valid, 0);
        check("rst_stop", program_stop, 0);
        check("rst_ovf", tx_overflow, 0);
        check("rst_bad", bad_access, 0);
        rst_in = 1'b0;

        // RAM write then read: data one cycle after address
        bus_write(32'h0000_0010, 8'hA5);
        check("ram_wr_hold", bus_rdata, 8'h00);
        bus_addr = 32'h0000_0010;
        bus_wr   = 1'b0;
        #1;
        check("ram_rd_not_yet", bus_rdata, 8'h00);
        step();
        check("ram_rd", bus_rdata, 8'hA5);
        bus_write(32'h0001_FFFF, 8'h5C);
        bus_read(32'h0001_FFFF);
        check("ram_top", bus_rdata, 8'h5C);

        // RX pop
        rx_valid = 1'b1;
        rx_data  = 8'h33;
        bus_addr = 32'h0003_0000;
        bus_wr   = 1'b0;
        #1;
        check("rx_pop_hi", rx_pop, 1);
        step();
        check("rx_data", bus_rdata, 8'h33);
        bus_addr = 32'h0000_0010;
        #1;
        check("rx_no_pop_ram", rx_pop, 0);
        step();
        check("ram_rd2", bus_rdata, 8'hA5);
        rx_valid = 1'b0;
        bus_addr = 32'h0003_0000;
        #1;
        check("rx_pop_lo", rx_pop, 0);
        step();
        check("rx_empty", bus_rdata, 8'h00);
        bus_read(32'h0000_0010);
        bus_read(32'h0003_0008);
        check("io_other_rd", bus_rdata, 8'h00);

        // TX FIFO fill, near-full, overflow
        tx_ready = 1'b0;
        bus_write(32'h0003_0000, 8'h41);
        bus_write(32'h0003_0000, 8'h00);
        bus_write(32'h0003_0000, 8'h42);
        check("tx_valid2", tx_valid, 1);
        check("tx_head", tx_data, 8'h41);
        check("tx_iofull2", io_buffer_full, 0);
        bus_write(32'h0003_0000, 8'h43);
        bus_write(32'h0003_0000, 8'h44);
        bus_write(32'h0003_0000, 8'h45);
        check("tx_iofull5", io_buffer_full, 0);
        bus_write(32'h0003_0000, 8'h46);
        check("tx_iofull6", io_buffer_full, 1);
        bus_write(32'h0003_0000, 8'h47);
        bus_write(32'h0003_0000, 8'h48);
        check("tx_ovf8", tx_overflow, 0);
        bus_write(32'h0003_0000, 8'h49);
        check("tx_ovf9", tx_overflow, 1);
        check("tx_head9", tx_data, 8'h41);
        // push while full with a simultaneous pop is accepted
        tx_ready = 1'b1;
        bus_write(32'h0003_0000, 8'h4A);
        check("tx_pushpop_head", tx_data, 8'h42);
        check("tx_pushpop_full", io_buffer_full, 1);
        exp_q1 = '{8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48, 8'h4A};
        bus_addr = 32'h0000_0010;
        bus_wr   = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("tx_drain%0d", i), tx_data, exp_q1[i]);
            step();
        end
        check("tx_empty", tx_valid, 0);
        check("tx_iofull_empty", io_buffer_full, 0);
        check("tx_ovf_sticky", tx_overflow, 1);

        // Reset mid-operation clears FIFO and pending read
        tx_ready = 1'b0;
        bus_write(32'h0003_0000, 8'h51);
        bus_addr = 32'h0000_0010;
        bus_wr   = 1'b0;
        rst_in   = 1'b1;
        step();
        rst_in = 1'b0;
        check("rst2_rdata", bus_rdata, 8'h00);
        check("rst2_txvalid", tx_valid, 0);
        check("rst2_ovf", tx_overflow, 0);

        // Cycle counter: counter==100 when 0x30004 is presented
        repeat (100) step();
        bus_read(32'h0003_0004);
        check("cnt100_b0", bus_rdata, 8'd100);
        bus_read(32'h0003_0005);
        check("cnt100_b1", bus_rdata, 8'h00);
        bus_read(32'h0003_0006);
        check("cnt100_b2", bus_rdata, 8'h00);
        bus_read(32'h0003_0007);
        check("cnt100_b3", bus_rdata, 8'h00);
        bus_addr = 32'h0000_0010;
        repeat (32'h1FF - 104) step();
        bus_read(32'h0003_0004);
        check("cnt1ff_b0", bus_rdata, 8'hFF);
        bus_read(32'h0003_0005);
        check("cnt1ff_b1", bus_rdata, 8'h01);
        bus_read(32'h0003_0006);
        check("cnt1ff_b2", bus_rdata, 8'h00);
        bus_read(32'h0003_0007);
        check("cnt1ff_b3", bus_rdata, 8'h00);

        // Program stop and terminator
        tx_ready = 1'b0;
        bus_write(32'h0003_0004, 8'h5A);
        check("stop_set", program_stop, 1);
        check("stop_txvalid", tx_valid, 1);
        check("stop_term", tx_data, 8'h00);
        bus_write(32'h0003_0000, 8'h41);
        bus_write(32'h0003_0004, 8'h5B);
        bus_write(32'h0000_0020, 8'h66);
        tx_ready = 1'b1;
        bus_read(32'h0000_0020);
        check("stop_ram_wr", bus_rdata, 8'h66);
        check("stop_one_entry", tx_valid, 0);
        tx_ready = 1'b0;
        rst_in   = 1'b1;
        step();
        rst_in = 1'b0;
        check("stop_cleared", program_stop, 0);

        // Out-of-range / aliasing
        bus_write(32'h0002_0010, 8'h77);
`ifdef MEM_BOUNDS_CHECK_EN
        check("oob_bad_pulse", bad_access, 1);
        bus_read(32'h0000_0010);
        check("oob_ram_kept", bus_rdata, 8'hA5);
        check("oob_bad_clear", bad_access, 0);
        bus_read(32'h0002_0010);
        check("oob_rd_zero", bus_rdata, 8'h00);
`else
        check("alias_bad", bad_access, 0);
        bus_read(32'h0000_0010);
        check("alias_ram", bus_rdata, 8'h77);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_io_responder.md
Name: mem_io_responder

Overview:
- Memory-side responder for the CPU's byte-wide memory bus: serves the address, write data, read data and write-enable signals plus io_buffer_full.
- Contains a 128KB single-port byte RAM, a UART TX FIFO, an RX pop interface, a 32-bit cycle counter and a program-stop flag.
- Sits in the top-level next to cpu, on the other end of its memory bus.
- Implements the bus contract exactly: read data returned the next cycle; a write completes in the cycle it is presented.

Parameters:
- RAM_ADDR_WIDTH, 17, byte address width of the RAM (2^17 = 128KB).
- TX_FIFO_LOG2, 3, log2 of TX FIFO depth (8 entries).
- FULL_MARGIN, 2, free-entry margin below which io_buffer_full asserts.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  synchronous active-high reset.
- bus_addr  input  32  byte address from CPU (CPU mem_a).
- bus_wdata  input  8  write data from CPU (CPU mem_dout).
- bus_wr  input  1  1 = write, 0 = read (CPU mem_wr).
- bus_rdata  output  8  read data to CPU (CPU mem_din), registered.
- io_buffer_full  output  1  TX FIFO near full, registered.
- rx_data  input  8  UART RX head byte.
- rx_valid  input  1  RX head byte present.
- rx_pop  output  1  one-cycle pop of RX head, combinational.
- tx_data  output  8  TX FIFO head byte.
- tx_valid  output  1  TX FIFO non-empty.
- tx_ready  input  1  UART accepts head byte this cycle.
- program_stop  output  1  sticky; set by write to 0x30004.
- tx_overflow  output  1  sticky; a TX push was dropped because the FIFO was full.
- bad_access  output  1  out-of-range access pulse (see Optional Feature).

Behaviour:
- One clock (clk_in). Reset is synchronous and active-high on rst_in, sampled on the rising edge.
- Reset values:
  - bus_rdata=0, io_buffer_full=0, tx_valid=0, program_stop=0, tx_overflow=0, bad_access=0.
  - FIFO pointers and count=0; cycle counter=0; snapshot=0.
  - RAM contents are not cleared.
- Reset mid-operation discards any pending read result and all FIFO contents.
- Every clock is one bus access. There is no idle cycle: holding the same address repeats the access.
- Decode:
  - IO region: bus_addr[17:16]==2'b11.
  - Otherwise RAM, addressed by bus_addr[RAM_ADDR_WIDTH-1:0].
- RAM read: bus_rdata <= ram[addr] at the edge. Data is valid in the cycle after the address.
- RAM write: ram[addr] <= bus_wdata at the edge. bus_rdata holds its previous value.
- IO read 0x30000:
  - bus_rdata <= rx_valid ? rx_data : 8'h00.
  - rx_pop = rx_valid in the same cycle.
- IO read 0x30004..0x30007:
  - A read of 0x30004 latches snapshot <= counter and returns counter[7:0].
  - Reads of 0x30005/6/7 return snapshot bytes 1/2/3, so a 4-byte read is coherent.
- IO write 0x30000:
  - Push bus_wdata to the TX FIFO if it is non-zero.
  - A zero byte is ignored.
  - If the FIFO is full, the byte is dropped and tx_overflow is set.
- IO write 0x30004:
  - program_stop <= 1.
  - Push 8'h00 terminator, bypassing the zero filter.
  - After program_stop is set, all further IO writes are ignored; RAM writes still execute.
- Other IO addresses: reads return 0; writes are ignored.
- Cycle counter: 32-bit, increments every cycle out of reset, wraps 0xFFFFFFFF -> 0.
- TX FIFO:
  - Pop when tx_valid && tx_ready. Pointers wrap modulo depth.
  - Simultaneous push and pop: count unchanged. A push while full is accepted only if a pop occurs in the same cycle.
- io_buffer_full <= (count_next >= 2^TX_FIFO_LOG2 - FULL_MARGIN).

Optional Feature:
- MEM_BOUNDS_CHECK_EN defined:
  - Any access with bus_addr[31:18]!=0, or with bus_addr[17:16]==2'b10, is out of range.
  - Out-of-range writes are suppressed; reads return 0.
  - bad_access pulses high in the following cycle.
- Undefined: addresses are masked to RAM_ADDR_WIDTH and alias into the RAM; bad_access is tied 0.

Test Plan:
- Write 0xA5 to 0x00010, then read 0x00010 -> bus_rdata==0xA5 exactly one cycle after the read address; the previous value is held during the write cycle.
- With tx_ready=0, write 0x41,0x00,0x42 to 0x30000 -> FIFO holds 2 entries, tx_data==0x41. With the defaults, the 6th accepted push raises io_buffer_full, and the 9th sets tx_overflow.
- Run 100 cycles after reset, then read 0x30004..0x30007 over 4 consecutive cycles -> the bytes form a value of about 100, and the upper bytes are not corrupted by counter increments.
- rx_valid=1, rx_data=0x33, read 0x30000 -> rx_pop high that cycle, bus_rdata==0x33 next cycle. With rx_valid=0 -> bus_rdata==0x00 and no pop.
- Write any byte to 0x30004 -> program_stop=1 and 0x00 is pushed; a later write of 0x41 to 0x30000 pushes nothing. Asserting rst_in then clears program_stop and the FIFO.
- With MEM_BOUNDS_CHECK_EN, write 0x77 to 0x20010 -> bad_access pulses and RAM[0x0010] is unchanged. Without the macro, RAM[0x0010]==0x77.
